serial_pattern_tx: RTL

- Bit-serial pattern transmitter: loads a WIDTH-bit pattern and shifts it out MSB-first on a single-bit line `x`.
- Each bit is held for a programmable number of clock cycles.
- It is the driving end of the line that RisingEdgeDetector monitors.
- Reports how many 0->1 transitions each pass produced, so a bench can cross-check the detector's pulse count against the transmitter's.

---
 rtl/serial_pattern_tx_pkg.sv | 17 +
 rtl/serial_pattern_tx_bit_period_div.sv | 35 +++
 rtl/serial_pattern_tx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/serial_pattern_tx_pkg.sv
// serial_pattern_tx_pkg
//   Shared definitions for the bit-serial pattern transmitter:
//   FSM state encoding, default geometry and the idle line level.
package serial_pattern_tx_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CPB   = 1;

  // Level driven on the serial line whenever nothing is being sent.
  localparam logic IDLE_LVL = 1'b0;

endpackage

// File: rtl/serial_pattern_tx_bit_period_div.sv
// bit_period_div
//   Counts 0..CYCLES_PER_BIT-1 while enabled and flags the last cycle of
//   each bit period so the transmitter knows when to advance.
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous reset, active low
//   i_clear    synchronous clear to 0 (wins over i_en)
//   i_en       count enable
//   o_bit_tick one-cycle pulse in the cycle the counter wraps
module bit_period_div #(
  parameter int CYCLES_PER_BIT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_bit_tick
);

  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap     = (r_cnt == LAST);
  assign o_bit_tick = i_en & ~i_clear & w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_en)    r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//   Loads a WIDTH-bit pattern and shifts it out MSB-first on x, holding each
//   bit CYCLES_PER_BIT clocks. Optionally repeats the pattern back-to-back
//   and reports the number of 0->1 transitions produced by each pass.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   start      begin a pass (ignored while busy or when abort is high)
//   pattern_in pattern, MSB sent first; latched on an accepted start
//   repeat_en  at end of pass, restart the latched pattern with no gap
//   abort      synchronous stop, highest priority after rst
//   x          serial line, idle low
//   busy       high while shifting
//   done       one-cycle pulse at the end of each pass
//   edge_cnt   rising edges on x during the last completed pass
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int CYCLES_PER_BIT = DEF_CPB,
  parameter int EDGE_W         = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  pattern_in,
  input  logic              repeat_en,
  input  logic              abort,
  output logic              x,
  output logic              busy,
  output logic              done,
  output logic [EDGE_W-1:0] edge_cnt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]     LAST_IDX = IW'(WIDTH - 1);
  localparam logic [EDGE_W-1:0] EC_ONE   = EDGE_W'(1);
  localparam logic [EDGE_W-1:0] EC_ZERO  = '0;

  state_t            r_state;
  logic [WIDTH-1:0]  r_pat;   // latched copy, reloaded on repeat
  logic [WIDTH-1:0]  r_sh;    // bit on the line sits in the MSB
  logic [IW-1:0]     r_idx;
  logic [EDGE_W-1:0] r_run;   // edges seen so far in the current pass
  logic [EDGE_W-1:0] r_edge;
  logic              r_x;
  logic              r_done;

  logic w_tick, w_clr, w_en;
  logic w_next_bit, w_rise, w_first_rise, w_load_rise;

  assign w_en  = (r_state == ST_SHIFT);
  assign w_clr = (r_state == ST_IDLE) | abort;

  bit_period_div #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_div (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_clear   (w_clr),
    .i_en      (w_en),
    .o_bit_tick(w_tick)
  );

  // Rise detection compares the bit about to go out with the level on the
  // line now, so the first bit of a repeated pass sees the prior last bit.
  assign w_next_bit   = r_sh[WIDTH-2];
  assign w_rise       = ~r_x & w_next_bit;
  assign w_first_rise = ~r_x & r_pat[WIDTH-1];
  assign w_load_rise  = (IDLE_LVL == 1'b0) & pattern_in[WIDTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pat   <= '0;
      r_sh    <= '0;
      r_idx   <= '0;
      r_run   <= '0;
      r_edge  <= '0;
      r_x     <= IDLE_LVL;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_x <= IDLE_LVL;
          if (start && !abort) begin
            r_pat   <= pattern_in;
            r_sh    <= pattern_in;
            r_x     <= pattern_in[WIDTH-1];
            r_idx   <= '0;
            r_run   <= w_load_rise ? EC_ONE : EC_ZERO;
            r_state <= ST_SHIFT;
          end
        end
        default: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_x     <= IDLE_LVL;
            r_idx   <= '0;
            r_run   <= '0;
          end else if (w_tick) begin
            if (r_idx == LAST_IDX) begin
              r_done <= 1'b1;
              r_edge <= r_run;
              r_idx  <= '0;
              if (repeat_en) begin
                r_sh  <= r_pat;
                r_x   <= r_pat[WIDTH-1];
                r_run <= w_first_rise ? EC_ONE : EC_ZERO;
              end else begin
                r_state <= ST_IDLE;
                r_x     <= IDLE_LVL;
                r_run   <= '0;
              end
            end else begin
              r_idx <= r_idx + IW'(1);
              r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
              r_x   <= w_next_bit;
              if (w_rise) r_run <= r_run + EC_ONE;
            end
          end
        end
      endcase
    end
  end

  assign x        = r_x;
  assign busy     = (r_state == ST_SHIFT);
  assign done     = r_done;
  assign edge_cnt = r_edge;

endmodule
